// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame master.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Frame headers as they appear on the wire, first transmitted byte in the MSBs
  localparam logic [31:0] HDR_WRITE     = 32'h74697277;
  localparam logic [31:0] HDR_DATA_WIRE = 32'h61746164;

  localparam int DEFAULT_BUFFER_SIZE = 240;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
// Loading N-1 on the edge that enters a phase makes tc_o rise on the
// phase's last cycle, so the phase lasts exactly N cycles.
module spi_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count down to zero and park there until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master: shifts one BUFFER_SIZE-bit frame out on MOSI, MSB first,
// while capturing the returned frame from MISO, then checks its 32-bit header.
//
// state | meaning
// IDLE  | bus released, waiting for start
// SETUP | SSEL low, first MOSI bit driven, waiting CS_SETUP cycles
// HIGH  | SCK high for CLK_DIV cycles (MISO sampled on entry)
// LOW   | SCK low for CLK_DIV cycles (next MOSI bit driven on entry)
// HOLD  | SCK low after last bit, SSEL held low for CS_HOLD cycles
// GAP   | SSEL high, busy still set for CS_GAP cycles
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int          BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
  parameter int          CLK_DIV     = 8,
  parameter int          CS_SETUP    = 8,
  parameter int          CS_HOLD     = 4,
  parameter int          CS_GAP      = 8,
  parameter logic [31:0] RX_HEADER   = HDR_DATA_WIRE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_frame,
  output logic [BUFFER_SIZE-1:0] rx_frame,
  output logic                   hdr_ok,
  output logic                   busy,
  output logic                   done,
  output logic                   SPI_SCK,
  output logic                   SPI_SSEL,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam int MAX_P = max_of(max_of(max_of(BUFFER_SIZE, CLK_DIV),
                                       max_of(CS_SETUP, CS_HOLD)), CS_GAP);
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_DIV   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUFFER_SIZE - 1);

  state_e                 state_q;
  logic [BUFFER_SIZE-1:0] tx_q;
  logic [BUFFER_SIZE-1:0] rx_q;
  logic [BUFFER_SIZE-1:0] rx_frame_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic                   sck_q;
  logic                   ssel_q;
  logic                   mosi_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   hdr_ok_q;

  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_tc;
  logic                   last_bit;

  assign last_bit = (bitcnt_q == LAST_BIT);

  spi_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // Reload the phase timer with the duration of whichever phase comes next
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        tmr_load = start;
        tmr_val  = LD_SETUP;
      end
      ST_SETUP, ST_LOW: begin
        tmr_load = tmr_tc;
        tmr_val  = LD_DIV;
      end
      ST_HIGH: begin
        tmr_load = tmr_tc;
        tmr_val  = last_bit ? LD_HOLD : LD_DIV;
      end
      ST_HOLD: begin
        tmr_load = tmr_tc;
        tmr_val  = LD_GAP;
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  // Frame sequencer; every bus-facing output is a flop driven from here.
  // tx_q holds the bits not yet placed on MOSI, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_frame_q <= '0;
      bitcnt_q   <= '0;
      sck_q      <= 1'b0;
      ssel_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hdr_ok_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tx_q     <= {tx_frame[BUFFER_SIZE-2:0], 1'b0};
            mosi_q   <= tx_frame[BUFFER_SIZE-1];
            rx_q     <= '0;
            bitcnt_q <= '0;
            ssel_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP, ST_LOW: begin
          if (tmr_tc) begin
            sck_q   <= 1'b1;
            rx_q    <= {rx_q[BUFFER_SIZE-2:0], SPI_MISO};
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tmr_tc) begin
            sck_q <= 1'b0;
            if (last_bit) begin
              state_q <= ST_HOLD;
            end else begin
              bitcnt_q <= bitcnt_q + CNT_W'(1);
              mosi_q   <= tx_q[BUFFER_SIZE-1];
              tx_q     <= {tx_q[BUFFER_SIZE-2:0], 1'b0};
              state_q  <= ST_LOW;
            end
          end
        end
        ST_HOLD: begin
          if (tmr_tc) begin
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_frame_q <= rx_q;
            hdr_ok_q   <= (rx_q[BUFFER_SIZE-1 -: 32] == RX_HEADER);
            done_q     <= 1'b1;
            state_q    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_frame = rx_frame_q;
  assign hdr_ok   = hdr_ok_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SPI_SCK  = sck_q;
  assign SPI_SSEL = ssel_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a behavioural slave per instance returns a
// chosen frame MSB-first (reloads on SSEL fall, advances on SCK fall), and a
// monitor counts SCK rises, captures MOSI, and times SSEL.
module tb_spi_frame_master;

  localparam int N_A   = 64;
  localparam int DIV_A = 4;
  localparam int N_B   = 240;
  localparam int DIV_B = 8;
  localparam int SETUP = 8;
  localparam int HOLD  = 4;
  localparam int GAP   = 8;
  localparam int LOW_A = SETUP + (2 * N_A - 1) * DIV_A + HOLD;
  localparam logic [31:0] HDR = 32'h61746164;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ---------------- instance A: 64-bit frames ----------------
  logic           start_a = 1'b0;
  logic [N_A-1:0] tx_a = '0;
  logic [N_A-1:0] rx_a;
  logic           hdr_a, busy_a, done_a, sck_a, ssel_a, mosi_a;
  logic           miso_a = 1'b0;

  spi_frame_master #(
    .BUFFER_SIZE (N_A), .CLK_DIV (DIV_A), .CS_SETUP (SETUP),
    .CS_HOLD (HOLD), .CS_GAP (GAP), .RX_HEADER (HDR)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .tx_frame (tx_a),
    .rx_frame (rx_a), .hdr_ok (hdr_a), .busy (busy_a), .done (done_a),
    .SPI_SCK (sck_a), .SPI_SSEL (ssel_a), .SPI_MOSI (mosi_a), .SPI_MISO (miso_a)
  );

  // ---------------- instance B: 240-bit frames ----------------
  logic           start_b = 1'b0;
  logic [N_B-1:0] tx_b = '0;
  logic [N_B-1:0] rx_b;
  logic           hdr_b, busy_b, done_b, sck_b, ssel_b, mosi_b;
  logic           miso_b = 1'b0;

  spi_frame_master #(
    .BUFFER_SIZE (N_B), .CLK_DIV (DIV_B), .CS_SETUP (SETUP),
    .CS_HOLD (HOLD), .CS_GAP (GAP), .RX_HEADER (HDR)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .tx_frame (tx_b),
    .rx_frame (rx_b), .hdr_ok (hdr_b), .busy (busy_b), .done (done_b),
    .SPI_SCK (sck_b), .SPI_SSEL (ssel_b), .SPI_MOSI (mosi_b), .SPI_MISO (miso_b)
  );

  // ---------------- slave + monitor A ----------------
  logic [N_A-1:0] resp_a = '0;
  logic [N_A-1:0] mosi_cap_a = '0;
  logic ssel_prev_a = 1'b1, sck_prev_a = 1'b0, busy_prev_a = 1'b0;
  int idx_a = -1, rises_a = 0, cur_low_a = 0, last_low_a = 0;
  int done_cnt_a = 0, busy_rise_a = 0, busy_fall_a = 0;

  always @(negedge clk) begin
    if (ssel_prev_a && !ssel_a) begin
      idx_a = N_A - 1;
      cur_low_a = 0;
    end else if (sck_prev_a && !sck_a) begin
      idx_a = idx_a - 1;
    end
    if (!sck_prev_a && sck_a) begin
      rises_a++;
      mosi_cap_a = {mosi_cap_a[N_A-2:0], mosi_a};
    end
    if (!ssel_a) cur_low_a++;
    if (!ssel_prev_a && ssel_a) last_low_a = cur_low_a;
    if (done_a) done_cnt_a++;
    if (!busy_prev_a && busy_a) busy_rise_a++;
    if (busy_prev_a && !busy_a) busy_fall_a++;
    miso_a = (!ssel_a && idx_a >= 0) ? resp_a[idx_a] : 1'b0;
    ssel_prev_a = ssel_a;
    sck_prev_a  = sck_a;
    busy_prev_a = busy_a;
  end

  // ---------------- slave + monitor B ----------------
  logic [N_B-1:0] resp_arr_b [4];
  logic [N_B-1:0] cur_resp_b = '0;
  logic [N_B-1:0] mosi_cap_b = '0;
  logic ssel_prev_b = 1'b1, sck_prev_b = 1'b0;
  int idx_b = -1, frame_idx_b = 0, cur_high_b = 0, last_high_b = 0;

  always @(negedge clk) begin
    if (ssel_prev_b && !ssel_b) begin
      idx_b = N_B - 1;
      cur_resp_b = resp_arr_b[frame_idx_b % 4];
      frame_idx_b++;
      last_high_b = cur_high_b;
      cur_high_b = 0;
    end else if (sck_prev_b && !sck_b) begin
      idx_b = idx_b - 1;
    end
    if (!sck_prev_b && sck_b) mosi_cap_b = {mosi_cap_b[N_B-2:0], mosi_b};
    if (ssel_b) cur_high_b++;
    miso_b = (!ssel_b && idx_b >= 0) ? cur_resp_b[idx_b] : 1'b0;
    ssel_prev_b = ssel_b;
    sck_prev_b  = sck_b;
  end

  // ---------------- helpers (stimulus/timing only) ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [N_B-1:0] rand240();
    logic [N_B-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[N_B-33:0], 32'($urandom())};
    return v;
  endfunction

  task automatic kick_a(input logic [N_A-1:0] tx, input logic [N_A-1:0] resp);
    resp_a  = resp;
    tx_a    = tx;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (done_a) ok = 1'b1;
    end
  endtask

  task automatic wait_idle_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (!busy_a) ok = 1'b1;
      else step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      obs = {ssel_a, sck_a, mosi_a, busy_a, done_a, hdr_a, (rx_a != '0)};
      n_cmp++;
      if (obs !== 7'b1000000) begin
        n_err++;
        $display("FAIL reset_idle_a cycle %0d: got %b expected 1000000", i, obs);
      end
    end
    obs = {ssel_b, sck_b, mosi_b, busy_b, done_b, hdr_b, (rx_b != '0)};
    n_cmp++;
    if (obs !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_idle_b: got %b expected 1000000", obs);
    end
  endtask

  // One frame on A with full checking against the slave's chosen response.
  task automatic frame_check_a(input string name, input logic [N_A-1:0] tx,
                               input logic [N_A-1:0] resp);
    int r0, d0;
    bit ok;
    r0 = rises_a;
    d0 = done_cnt_a;
    kick_a(tx, resp);
    wait_done_a(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s done_timeout: got no done expected done within 3000 cycles", name);
    end
    n_cmp++;
    if (rx_a !== resp) begin
      n_err++;
      $display("FAIL %s rx_frame: got %h expected %h", name, rx_a, resp);
    end
    n_cmp++;
    if (hdr_a !== (resp[N_A-1 -: 32] == HDR)) begin
      n_err++;
      $display("FAIL %s hdr_ok: got %b expected %b", name, hdr_a, (resp[N_A-1 -: 32] == HDR));
    end
    n_cmp++;
    if (mosi_cap_a !== tx) begin
      n_err++;
      $display("FAIL %s mosi_bits: got %h expected %h", name, mosi_cap_a, tx);
    end
    n_cmp++;
    if (rises_a - r0 != N_A) begin
      n_err++;
      $display("FAIL %s sck_rises: got %0d expected %0d", name, rises_a - r0, N_A);
    end
    n_cmp++;
    if (last_low_a != LOW_A) begin
      n_err++;
      $display("FAIL %s ssel_low: got %0d expected %0d", name, last_low_a, LOW_A);
    end
    wait_idle_a(ok);
    n_cmp++;
    if (!ok || done_cnt_a - d0 != 1) begin
      n_err++;
      $display("FAIL %s done_pulses: got %0d (idle=%0b) expected 1", name, done_cnt_a - d0, ok);
    end
  endtask

  task automatic test_single_frame();
    frame_check_a("single", 64'h74697277_DEADBEEF, 64'h61746164_01234567);
  endtask

  task automatic test_bad_header();
    frame_check_a("bad_hdr", 64'h74697277_00C0FFEE, 64'h0);
  endtask

  task automatic test_random_frames();
    logic [N_A-1:0] tx, resp;
    for (int k = 0; k < 5; k++) begin
      tx   = {32'($urandom()), 32'($urandom())};
      resp = {32'($urandom()), 32'($urandom())};
      if ($urandom_range(0, 1) == 1) resp[N_A-1 -: 32] = HDR;
      frame_check_a("random", tx, resp);
    end
  endtask

  task automatic test_start_while_busy();
    logic [N_A-1:0] tx, resp;
    int br0, bf0, d0;
    bit ok;
    tx   = {32'($urandom()), 32'($urandom())};
    resp = {HDR, 32'($urandom())};
    br0 = busy_rise_a;
    bf0 = busy_fall_a;
    d0  = done_cnt_a;
    kick_a(tx, resp);
    tx_a = ~tx;
    repeat (100) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done_a(ok);
    n_cmp++;
    if (!ok || rx_a !== resp) begin
      n_err++;
      $display("FAIL busy_start rx_frame: got %h expected %h", rx_a, resp);
    end
    n_cmp++;
    if (mosi_cap_a !== tx) begin
      n_err++;
      $display("FAIL busy_start mosi_bits: got %h expected %h", mosi_cap_a, tx);
    end
    // start held only on the edge that leaves GAP
    repeat (GAP - 1) step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL gap_exit busy: got %b expected 0", busy_a);
    end
    repeat (700) step();
    n_cmp++;
    if (busy_rise_a - br0 != 1 || busy_fall_a - bf0 != 1) begin
      n_err++;
      $display("FAIL busy_start busy_edges: got rise %0d fall %0d expected 1 1",
               busy_rise_a - br0, busy_fall_a - bf0);
    end
    n_cmp++;
    if (done_cnt_a - d0 != 1) begin
      n_err++;
      $display("FAIL busy_start frames: got %0d expected 1", done_cnt_a - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [N_A-1:0] tx;
    int r0, d0;
    bit ok;
    frame_check_a("pre_reset", 64'h74697277_12345678, 64'h0);
    tx = {32'($urandom()), 32'($urandom())};
    r0 = rises_a;
    kick_a(tx, {HDR, 32'($urandom())});
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (rises_a - r0 >= 20) ok = 1'b1;
      else step();
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL mid_reset reach_bit20: got %0d rises expected 20", rises_a - r0);
    end
    #2;
    d0 = done_cnt_a;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ssel_a, sck_a, busy_a, done_a} !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_reset bus_release: got %b expected 1000", {ssel_a, sck_a, busy_a, done_a});
    end
    n_cmp++;
    if (rx_a !== '0) begin
      n_err++;
      $display("FAIL mid_reset rx_frame: got %h expected 0", rx_a);
    end
    repeat (10) step();
    rst_n = 1'b1;
    repeat (20) step();
    n_cmp++;
    if (done_cnt_a != d0 || rx_a !== '0) begin
      n_err++;
      $display("FAIL mid_reset no_done: got %0d dones rx %h expected 0 dones rx 0",
               done_cnt_a - d0, rx_a);
    end
    frame_check_a("post_reset", {32'($urandom()), 32'($urandom())}, {HDR, 32'($urandom())});
  endtask

  task automatic test_back_to_back();
    logic [N_B-1:0] tx_arr [3];
    int seen;
    for (int k = 0; k < 3; k++) begin
      tx_arr[k]     = rand240();
      resp_arr_b[k] = rand240();
      if (k != 1) resp_arr_b[k][N_B-1 -: 32] = HDR;
    end
    resp_arr_b[3] = '0;
    seen = 0;
    tx_b = tx_arr[0];
    start_b = 1'b1;
    for (int i = 0; i < 20000 && seen < 3; i++) begin
      step();
      if (frame_idx_b >= 1 && frame_idx_b < 3) tx_b = tx_arr[frame_idx_b];
      if (frame_idx_b >= 3) start_b = 1'b0;
      if (done_b) begin
        n_cmp++;
        if (rx_b !== resp_arr_b[seen]) begin
          n_err++;
          $display("FAIL b2b rx_frame[%0d]: got %h expected %h", seen, rx_b, resp_arr_b[seen]);
        end
        n_cmp++;
        if (hdr_b !== (resp_arr_b[seen][N_B-1 -: 32] == HDR)) begin
          n_err++;
          $display("FAIL b2b hdr_ok[%0d]: got %b expected %b", seen, hdr_b,
                   (resp_arr_b[seen][N_B-1 -: 32] == HDR));
        end
        n_cmp++;
        if (mosi_cap_b !== tx_arr[seen]) begin
          n_err++;
          $display("FAIL b2b mosi_bits[%0d]: got %h expected %h", seen, mosi_cap_b, tx_arr[seen]);
        end
        if (seen > 0) begin
          n_cmp++;
          if (last_high_b < GAP + 1) begin
            n_err++;
            $display("FAIL b2b ssel_gap[%0d]: got %0d expected >= %0d", seen, last_high_b, GAP + 1);
          end
        end
        seen++;
      end
    end
    start_b = 1'b0;
    n_cmp++;
    if (seen != 3) begin
      n_err++;
      $display("FAIL b2b frame_count: got %0d expected 3", seen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_bad_header();
    test_random_frames();
    test_start_while_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI mode-0 master that initiates one full-frame transfer against the board's SPI frame slave. Intended uses: FPGA-to-FPGA expansion links and a self-test/loopback harness on the same board. Each transfer shifts out a BUFFER_SIZE-bit command frame MSB-first on MOSI and captures the simultaneously returned feedback frame from MISO. The captured frame's leading 32 bits are checked against the expected response header.

Parameters:
- BUFFER_SIZE, 240: frame length in bits (≥ 33).
- CLK_DIV, 8: SCK half-period in clk cycles (≥ 4, so the slave's 3-flop SCK synchroniser sees every edge).
- CS_SETUP, 8: clk cycles from SSEL low to first SCK rise (≥ 4; the slave loads MISO on the SSEL falling edge).
- CS_HOLD, 4: clk cycles from last SCK fall to SSEL high.
- CS_GAP, 8: minimum SSEL-high cycles before the next frame may start.
- RX_HEADER, 32'h61746164: expected rx_frame[BUFFER_SIZE-1 -: 32]. This is the wire order of the "data" header.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle request. Sampled only in IDLE.
- tx_frame, in, BUFFER_SIZE: outgoing frame. Latched on an accepted start.
- rx_frame, out, BUFFER_SIZE: last completed received frame.
- hdr_ok, out, 1: rx_frame header equals RX_HEADER. Updated with rx_frame.
- busy, out, 1: high from the cycle after an accepted start until GAP ends.
- done, out, 1: one-cycle pulse when a frame completes.
- SPI_SCK, out, 1: serial clock. Idle low.
- SPI_SSEL, out, 1: chip select. Active low.
- SPI_MOSI, out, 1: master data out.
- SPI_MISO, in, 1: slave data in.

Behaviour:
- Reset (async, rst_n=0): state IDLE. Outputs: SPI_SSEL=1, SPI_SCK=0, SPI_MOSI=0, busy=0, done=0, hdr_ok=0, rx_frame=0. All counters cleared.
- Reset mid-frame: the bus is released on the same edge. SSEL rises, SCK goes low, and rx_frame does not update.
- All SPI outputs are driven directly from flops; no combinational paths.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE:
  - start=1 latches tx_frame into the tx shift register and clears bitcnt and the phase counter.
  - Next cycle: SSEL=0, MOSI=tx_frame[BUFFER_SIZE-1], busy=1, state SETUP.
- SETUP: after CS_SETUP cycles, drive SCK=1, shift SPI_MISO into the rx shift register LSB, and go to HIGH.
- HIGH: after CLK_DIV cycles, drive SCK=0.
  - If bitcnt == BUFFER_SIZE-1, go to HOLD.
  - Otherwise increment bitcnt, shift the tx register left, drive MOSI with the next bit, and go to LOW.
- LOW: after CLK_DIV cycles, drive SCK=1, shift in SPI_MISO, and go to HIGH.
- HOLD: after CS_HOLD cycles, drive SSEL=1, MOSI=0. In the same cycle:
  - rx_frame <= rx shift register,
  - hdr_ok <= (header match),
  - done=1 for one cycle,
  - state GAP.
- GAP: after CS_GAP cycles, busy=0 and state IDLE.
- Timing:
  - MOSI changes only on SCK-falling cycles or in IDLE→SETUP.
  - MISO is sampled exactly on the cycle SCK is driven high.
  - Exactly BUFFER_SIZE rising edges per frame.
  - SSEL low time = CS_SETUP + (2·BUFFER_SIZE−1)·CLK_DIV + CS_HOLD cycles.
- start while busy: ignored, with no queuing. tx_frame changes after acceptance have no effect.
- start on the same cycle GAP ends: ignored, because state is not yet IDLE.
- Counters use width $clog2 of the largest parameter + 1; no wrap occurs within legal parameters.

Decomposition:
- Shared package spi_frame_pkg:
  - state enum,
  - header constants HDR_WRITE=32'h74697277 and HDR_DATA_WIRE=32'h61746164,
  - default BUFFER_SIZE=240.
- One natural sub-module: spi_phase_timer, a loadable down-counter with a terminal pulse, reused for the SETUP/HIGH/LOW/HOLD/GAP durations.
- The shift registers stay in the top.

Test Plan (BUFFER_SIZE=64, CLK_DIV=4 unless stated; bench models the slave: MISO shifts on SCK falls, resets on SSEL fall):
- Reset: rst_n low, then high, with no start → SSEL=1, SCK=0, MOSI=0, busy=0, rx_frame=0 held for 100 cycles.
- Single frame:
  - Stimulus: tx_frame=64'h74697277_DEADBEEF, slave returns 64'h61746164_01234567.
  - Required: 64 SCK rises; MOSI bits match MSB-first; rx_frame=64'h6174616401234567; hdr_ok=1; done pulses once.
  - Required: SSEL low for 8+127·4+4=520 cycles.
- Bad header: slave returns 64'h0 → rx_frame=0, hdr_ok=0, done pulses.
- Start while busy: second start mid-frame and on the GAP-exit cycle → ignored; exactly one frame occurs and busy stays contiguous.
- Async reset mid-frame: rst_n low after 20 bits → SSEL=1 and SCK=0 immediately, no done, rx_frame keeps its prior value (0); a new start afterwards completes normally.
- Back-to-back (BUFFER_SIZE=240, CLK_DIV=8): start held high → frames separated by ≥ CS_GAP+1 SSEL-high cycles, and each rx_frame is correct.
